load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage between execute and writeback. Takes the ALU-computed address and store data for RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW, drives a word-addressed data-memory bus with byte enables, and waits on a variable-latency acknowledge. It returns a sign- or zero-extended load result that feeds the writeback select mux (`b` input, memory side). While an access is in flight it stalls the processor.

## Interface
Parameters:
- `TIMEOUT`, default 255: max cycles in WAIT before a bus error; counter width = $clog2(TIMEOUT+1).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  memory instruction present this cycle
- `is_store`  in  1  1 = store, 0 = load
- `funct3`  in  3  access size/sign
- `addr`  in  32  byte address from ALU
- `wdata`  in  32  rs2 store data
- `stall`  out  1  hold pipeline/PC
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`: misaligned, illegal funct3 or timeout
- `rdata`  out  32  extended load result, held until next `done`
- `mem_req`  out  1  bus request
- `mem_we`  out  1  bus write
- `mem_addr`  out  32  {addr[31:2], 2'b00}
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-aligned store data
- `mem_rdata`  in  32  bus read word, valid with `mem_ack`
- `mem_ack`  in  1  bus completion

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: `req_valid` = 1 and request legal -> latch is_store, funct3, addr[1:0], mem_addr, mem_be, mem_wdata; go WAIT. Illegal request -> go DONE with err = 1, rdata = 0, no bus cycle.
- Illegal: funct3 ∈ {011,110,111}; stores with funct3[2] = 1; halfword with addr[0] = 1; word with addr[1:0] ≠ 00.
- WAIT: `mem_req` = 1, bus outputs held stable. `mem_ack` -> capture extended `mem_rdata` (loads only; stores leave rdata unchanged), err = 0, go DONE. No ack and counter = TIMEOUT-1 -> err = 1, go DONE. Ack and timeout in same cycle: ack wins.
- DONE: `done` = 1 for one cycle; go IDLE. New request not accepted in DONE.
- `stall` = (IDLE & req_valid) | WAIT. Stall is 0 in DONE, so the processor advances and writes back `rdata` that cycle.
- Byte enables: SB 4'b0001 << addr[1:0], wdata[7:0] replicated ×4; SH addr[1] ? 4'b1100 : 4'b0011, wdata[15:0] replicated ×2; SW 4'b1111.
- Load extend: select byte lane addr[1:0] / half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
- `mem_we` = is_store. Outside WAIT: mem_req = 0, mem_we = 0, mem_be = 0.

## Timing
- Reset (async, immediate): state IDLE, stall = 0 (unless req_valid), done = 0, err = 0, rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0, counter 0. Reset in WAIT drops `mem_req` immediately, and the access is abandoned.
- Accept at edge N; mem_req high from N+1; ack sampled at edge M; done/rdata valid in cycle M+1. Minimum latency, ack in the first WAIT cycle: done 2 cycles after accept.
- Illegal request: done + err in cycle after accept, 1-cycle stall.
- `mem_ack` outside WAIT is ignored.

## Structure
- Package `lsu_pkg`: state enum `lsu_state_t` (IDLE, WAIT, DONE); funct3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
- Sub-module `load_extend` (combinational): inputs funct3, addr[1:0], word; output 32-bit extended data. Top holds the FSM, timeout counter and the byte-enable/store-lane logic.

## Test plan
- LB addr 0x103, mem_rdata 0x80FF_1234, ack in the 1st WAIT cycle -> mem_addr 0x100, mem_be 0, rdata 0xFFFF_FF80, done 2 cycles after accept, err 0.
- LHU addr 0x202, mem_rdata 0xBEEF_0000, ack after 5 cycles -> rdata 0x0000_BEEF; stall high for 6 cycles, mem_req held for 5.
- SB addr 0x11, wdata 0x0000_00A5 -> mem_be 4'b0010, mem_wdata 0xA5A5_A5A5, mem_we 1; rdata unchanged.
- LW addr 0x6 -> no mem_req, done + err next cycle, rdata 0. Funct3 011 gives the same result.
- TIMEOUT = 4, no ack -> mem_req for exactly 4 cycles, then done + err. Repeat with ack on the 4th cycle -> err 0.
- rst_n low in the 2nd WAIT cycle -> mem_req 0 same cycle, state IDLE, all outputs at reset values; next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_t : access FSM states
//   F3_*        : RISC-V load/store funct3 encodings
//   lsu_legal() : request legality (funct3 + alignment)
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads; halfwords need even addresses,
    // words need 4-byte alignment.
    function automatic logic lsu_legal(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !is_store && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data lane select and extension (combinational).
//   funct3  : access size/sign
//   addr_lo : byte offset within the word
//   word    : raw bus read word
//   data    : sign/zero-extended load result (LW passes the word through)
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        unique case (addr_lo)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data = {24'd0, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data = {16'd0, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage. Accepts one load/store at a time, drives a
// word-addressed bus with byte enables, waits for a variable-latency ack
// (bounded by TIMEOUT cycles) and returns an extended load result.
//   clk, rst_n           : clock, async active-low reset
//   req_valid, is_store,
//   funct3, addr, wdata  : request from execute
//   stall                : hold pipeline while accepting / waiting
//   done, err, rdata     : completion pulse, error flag, held load result
//   mem_*                : data-memory bus
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    lsu_state_t      state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            req_legal;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new;
    logic [31:0]     ext_data;

    load_extend u_load_extend (
        .funct3  (f3_q),
        .addr_lo (off_q),
        .word    (mem_rdata),
        .data    (ext_data)
    );

    // Byte enables and lane-replicated store data for the incoming request.
    // Loads drive no byte enables.
    always_comb begin
        req_legal = lsu_legal(is_store, funct3, addr[1:0]);
        be_new    = 4'b0000;
        wdata_new = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
        if (!is_store) begin
            be_new = 4'b0000;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_addr_d  = mem_addr_q;
        be_d        = be_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        is_store_d  = is_store;
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                        mem_addr_d  = {addr[31:2], 2'b00};
                        be_d        = be_new;
                        mem_wdata_d = wdata_new;
                        cnt_d       = '0;
                        state_d     = WAIT;
                    end else begin
                        // Rejected without touching the bus.
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                // Ack takes priority over a simultaneous timeout.
                if (mem_ack) begin
                    err_d = 1'b0;
                    if (!is_store_q) begin
                        rdata_d = ext_data;
                    end
                    state_d = DONE;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            mem_addr_q  <= 32'd0;
            be_q        <= 4'd0;
            mem_wdata_q <= 32'd0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_addr_q  <= mem_addr_d;
            be_q        <= be_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        mem_req   = (state_q == WAIT);
        mem_we    = mem_req && is_store_q;
        mem_be    = mem_req ? be_q : 4'b0000;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        done      = (state_q == DONE);
        err       = err_q;
        rdata     = rdata_q;
        stall     = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Two instances: u_main (default
// TIMEOUT) and u_tmo (TIMEOUT = 4); `sel` routes request/ack to one of them
// and muxes its outputs onto the o_* observation nets.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req;
    logic        ack;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;

    logic        stall_m, done_m, err_m, mem_req_m, mem_we_m;
    logic [31:0] rdata_m, mem_addr_m, mem_wdata_m;
    logic [3:0]  mem_be_m;
    logic        stall_t, done_t, err_t, mem_req_t, mem_we_t;
    logic [31:0] rdata_t, mem_addr_t, mem_wdata_t;
    logic [3:0]  mem_be_t;

    logic        o_stall, o_done, o_err, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    int checks;
    int failures;
    logic [31:0] mrd [2];

    load_store_unit u_main (
        .clk(clk), .rst_n(rst_n), .req_valid(req && !sel), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall_m), .done(done_m),
        .err(err_m), .rdata(rdata_m), .mem_req(mem_req_m), .mem_we(mem_we_m),
        .mem_addr(mem_addr_m), .mem_be(mem_be_m), .mem_wdata(mem_wdata_m),
        .mem_rdata(mem_rdata), .mem_ack(ack && !sel)
    );

    load_store_unit #(.TIMEOUT(4)) u_tmo (
        .clk(clk), .rst_n(rst_n), .req_valid(req && sel), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall_t), .done(done_t),
        .err(err_t), .rdata(rdata_t), .mem_req(mem_req_t), .mem_we(mem_we_t),
        .mem_addr(mem_addr_t), .mem_be(mem_be_t), .mem_wdata(mem_wdata_t),
        .mem_rdata(mem_rdata), .mem_ack(ack && sel)
    );

    assign o_stall     = sel ? stall_t     : stall_m;
    assign o_done      = sel ? done_t      : done_m;
    assign o_err       = sel ? err_t       : err_m;
    assign o_rdata     = sel ? rdata_t     : rdata_m;
    assign o_mem_req   = sel ? mem_req_t   : mem_req_m;
    assign o_mem_we    = sel ? mem_we_t    : mem_we_m;
    assign o_mem_addr  = sel ? mem_addr_t  : mem_addr_m;
    assign o_mem_be    = sel ? mem_be_t    : mem_be_m;
    assign o_mem_wdata = sel ? mem_wdata_t : mem_wdata_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (from the architectural rules) -------
    function automatic logic ref_legal(input logic st, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic bad;
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        bad = bad || (st && f3[2]);
        bad = bad || (((f3 == 3'd1) || (f3 == 3'd5)) && off[0]);
        bad = bad || ((f3 == 3'd2) && (off != 2'd0));
        return !bad;
    endfunction

    function automatic logic [3:0] ref_be(input logic st, input logic [2:0] f3,
                                          input logic [1:0] off);
        if (!st) return 4'b0000;
        if (f3 == 3'd0) return 4'b0001 << off;
        if (f3 == 3'd1) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (f3 == 3'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0]        sb, sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sb = w >> (8 * off);
        sh = w >> (16 * off[1]);
        b  = sb[7:0];
        h  = sh[15:0];
        case (f3)
            3'd0:    return int'(b);
            3'd4:    return {24'd0, sb[7:0]};
            3'd1:    return int'(h);
            3'd5:    return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // One full access on the selected instance. Must be entered between edges
    // with the instance idle; returns one edge + 1 after DONE (instance idle).
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rw,
                             input int ack_at, input int tmo,
                             output int nreq, output int nstall);
        logic       ok;
        logic       acked;
        logic       eerr;
        logic [3:0] ebe;
        logic [31:0] ewd;
        int         k;
        ok   = ref_legal(st, f3, a[1:0]);
        ebe  = ref_be(st, f3, a[1:0]);
        ewd  = ref_wdata(f3, wd);
        nreq = 0;
        nstall = 0;
        is_store = st; funct3 = f3; addr = a; wdata = wd; req = 1'b1; ack = 1'b0;
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            failures++;
            $display("FAIL accept_stall: got %b want 1", o_stall);
        end
        nstall++;
        @(posedge clk); #1;
        // Post-accept input noise must not disturb the access.
        req = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        #1;
        if (!ok) begin
            mrd[sel] = 32'd0;
            checks++;
            if ({o_done, o_err, o_rdata, o_mem_req, o_stall} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL illegal_done: got done=%b err=%b rdata=%h req=%b stall=%b want 1 1 0 0 0",
                         o_done, o_err, o_rdata, o_mem_req, o_stall);
            end
        end else begin
            k = 0;
            acked = 1'b0;
            while (!acked && k < tmo) begin
                k++;
                checks++;
                if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_stall, o_done} !==
                    {1'b1, st, ebe, a[31:2], 2'b00, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL wait_bus cyc%0d: got req=%b we=%b be=%b addr=%h stall=%b done=%b want 1 %b %b %h 1 0",
                             k, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_stall, o_done,
                             st, ebe, {a[31:2], 2'b00});
                end
                if (st) begin
                    checks++;
                    if (o_mem_wdata !== ewd) begin
                        failures++;
                        $display("FAIL store_wdata: got %h want %h", o_mem_wdata, ewd);
                    end
                end
                nreq++;
                nstall++;
                if (k == ack_at) begin
                    ack = 1'b1;
                    mem_rdata = rw;
                    acked = 1'b1;
                end else begin
                    mem_rdata = $urandom;
                end
                @(posedge clk); #1;
                ack = 1'b0;
                mem_rdata = $urandom;
                #1;
            end
            eerr = !acked;
            if (acked && !st) mrd[sel] = ref_ext(f3, a[1:0], rw);
            checks++;
            if ({o_done, o_err, o_rdata, o_stall, o_mem_req, o_mem_be} !==
                {1'b1, eerr, mrd[sel], 1'b0, 1'b0, 4'b0000}) begin
                failures++;
                $display("FAIL done_cycle: got done=%b err=%b rdata=%h stall=%b req=%b be=%b want 1 %b %h 0 0 0",
                         o_done, o_err, o_rdata, o_stall, o_mem_req, o_mem_be, eerr, mrd[sel]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({o_done, o_err} !== 2'b00) begin
            failures++;
            $display("FAIL done_pulse_width: got done=%b err=%b want 0 0", o_done, o_err);
        end
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; ack = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0;
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({o_stall, o_done, o_err, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_be,
                 o_mem_wdata} !== 105'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d: got stall=%b done=%b err=%b rdata=%h req=%b addr=%h be=%b wdata=%h want all 0",
                         s, o_stall, o_done, o_err, o_rdata, o_mem_req, o_mem_addr, o_mem_be, o_mem_wdata);
            end
        end
        sel = 1'b0;
        mrd[0] = 32'd0;
        mrd[1] = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int nreq, nstall;
        sel = 1'b0;
        do_access(1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_1234, 1, 255, nreq, nstall);
        checks++;
        if ({o_rdata, nreq, nstall} !== {32'hFFFF_FF80, 32'd1, 32'd2}) begin
            failures++;
            $display("FAIL lb_latency: got rdata=%h req=%0d stall=%0d want ffffff80 1 2",
                     o_rdata, nreq, nstall);
        end
        do_access(1'b0, 3'd5, 32'h0000_0202, 32'd0, 32'hBEEF_0000, 5, 255, nreq, nstall);
        checks++;
        if ({o_rdata, nreq, nstall} !== {32'h0000_BEEF, 32'd5, 32'd6}) begin
            failures++;
            $display("FAIL lhu_slow: got rdata=%h req=%0d stall=%0d want 0000beef 5 6",
                     o_rdata, nreq, nstall);
        end
        do_access(1'b1, 3'd0, 32'h0000_0011, 32'h0000_00A5, 32'h1111_1111, 1, 255, nreq, nstall);
        checks++;
        if (o_rdata !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL sb_keeps_rdata: got %h want 0000beef", o_rdata);
        end
        do_access(1'b0, 3'd2, 32'h0000_0006, 32'd0, 32'd0, 1, 255, nreq, nstall);
        checks++;
        if ({o_rdata, nreq, nstall} !== {32'd0, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL lw_misaligned: got rdata=%h req=%0d stall=%0d want 0 0 1",
                     o_rdata, nreq, nstall);
        end
        do_access(1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'h1234_5678, 2, 255, nreq, nstall);
        do_access(1'b0, 3'd3, 32'h0000_0100, 32'd0, 32'd0, 1, 255, nreq, nstall);
        checks++;
        if ({o_rdata, nreq, nstall} !== {32'd0, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL funct3_011: got rdata=%h req=%0d stall=%0d want 0 0 1",
                     o_rdata, nreq, nstall);
        end
    endtask

    task automatic test_timeout();
        int nreq, nstall;
        sel = 1'b1;
        do_access(1'b0, 3'd2, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 0, 4, nreq, nstall);
        checks++;
        if (nreq !== 4) begin
            failures++;
            $display("FAIL timeout_req_cycles: got %0d want 4", nreq);
        end
        do_access(1'b0, 3'd2, 32'h0000_0044, 32'd0, 32'hCAFE_F00D, 4, 4, nreq, nstall);
        checks++;
        if (o_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL ack_on_last_cycle: got rdata=%h want cafef00d", o_rdata);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int nreq, nstall;
        sel = 1'b0;
        is_store = 1'b1; funct3 = 3'd2; addr = 32'h0000_0040; wdata = 32'h5555_AAAA; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_stall, o_done, o_err, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_be,
             o_mem_wdata} !== 105'd0) begin
            failures++;
            $display("FAIL reset_in_wait: got stall=%b req=%b we=%b addr=%h be=%b wdata=%h rdata=%h want all 0",
                     o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_rdata);
        end
        mrd[0] = 32'd0;
        mrd[1] = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 3'd1, 32'h0000_0082, 32'd0, 32'h9ABC_0000, 2, 255, nreq, nstall);
        checks++;
        if (o_rdata !== 32'hFFFF_9ABC) begin
            failures++;
            $display("FAIL after_reset_lh: got %h want ffff9abc", o_rdata);
        end
    endtask

    task automatic test_ack_outside_wait();
        sel = 1'b0;
        ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        ack = 1'b0;
        #1;
        checks++;
        if ({o_done, o_stall, o_mem_req, o_rdata} !== {1'b0, 1'b0, 1'b0, mrd[0]}) begin
            failures++;
            $display("FAIL stray_ack: got done=%b stall=%b req=%b rdata=%h want 0 0 0 %h",
                     o_done, o_stall, o_mem_req, o_rdata, mrd[0]);
        end
    endtask

    task automatic test_done_ignores_req();
        sel = 1'b0;
        is_store = 1'b0; funct3 = 3'd7; addr = 32'h0; req = 1'b1;
        @(posedge clk); #1;
        funct3 = 3'd2; addr = 32'h0000_0080;
        #1;
        checks++;
        if ({o_done, o_err, o_stall, o_mem_req} !== 4'b1100) begin
            failures++;
            $display("FAIL done_with_req: got done=%b err=%b stall=%b req=%b want 1 1 0 0",
                     o_done, o_err, o_stall, o_mem_req);
        end
        @(posedge clk); #1;
        checks++;
        if ({o_done, o_stall, o_mem_req} !== 3'b010) begin
            failures++;
            $display("FAIL idle_after_done: got done=%b stall=%b req=%b want 0 1 0",
                     o_done, o_stall, o_mem_req);
        end
        @(posedge clk); #1;
        req = 1'b0;
        ack = 1'b1;
        mem_rdata = 32'h0BAD_CAFE;
        #1;
        checks++;
        if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h0000_0080}) begin
            failures++;
            $display("FAIL accept_after_done: got req=%b addr=%h want 1 00000080",
                     o_mem_req, o_mem_addr);
        end
        @(posedge clk); #1;
        ack = 1'b0;
        mrd[0] = 32'h0BAD_CAFE;
        #1;
        checks++;
        if ({o_done, o_err, o_rdata} !== {1'b1, 1'b0, 32'h0BAD_CAFE}) begin
            failures++;
            $display("FAIL lw_after_done: got done=%b err=%b rdata=%h want 1 0 0badcafe",
                     o_done, o_err, o_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_random();
        int nreq, nstall;
        logic [2:0] f3;
        sel = 1'b0;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            do_access(1'($urandom), f3, $urandom, $urandom, $urandom,
                      int'($urandom_range(1, 4)), 255, nreq, nstall);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sel = 1'b0;
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid_access();
        test_ack_outside_wait();
        test_done_ignores_req();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
